// File: rtl/mvm_host_driver.sv
// Host-side sequencer for a K x K matrix-vector multiply engine: streams the matrix
// and vector in, launches the compute, buffers the K result words and drains them.
module mvm_host_driver #(
    parameter int K       = 32,
    parameter int B       = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [B-1:0]   s_data,
    input  logic           reuse_matrix,
    output logic           loadMatrix,
    output logic           loadVector,
    output logic           start,
    output logic [B-1:0]   data_in,
    input  logic           done,
    input  logic [2*B-1:0] data_out,
    output logic           r_valid,
    input  logic           r_ready,
    output logic [2*B-1:0] r_data,
    output logic           r_last,
    output logic           busy,
    output logic           error
);

    localparam int CW = $clog2(K*K+1);
    localparam int VW = $clog2(K+1);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] MAT_LAST  = CW'(K*K-1);
    localparam logic [VW-1:0] VEC_LAST  = VW'(K-1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT-1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LM_CMD  = 4'd1,
        LM_DATA = 4'd2,
        LV_CMD  = 4'd3,
        LV_DATA = 4'd4,
        START   = 4'd5,
        WAIT    = 4'd6,
        CAPTURE = 4'd7,
        DRAIN   = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   elem_cnt_q, elem_cnt_d;
    logic [VW-1:0]   vec_cnt_q, vec_cnt_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            matrix_loaded_q, matrix_loaded_d;
    logic            error_q, error_d;
    logic [2*B-1:0]  res_buf_q [K];
    logic [2*B-1:0]  res_buf_d [K];

    logic            s_ready_q, s_ready_d;
    logic            load_matrix_q, load_matrix_d;
    logic            load_vector_q, load_vector_d;
    logic            start_q, start_d;
    logic            r_valid_q, r_valid_d;
    logic            r_last_q, r_last_d;
    logic [2*B-1:0]  r_data_q, r_data_d;
    logic            busy_q, busy_d;

    // Next-state, counter, buffer and output decode; outputs follow the next state
    // so every command strobe is a flop that is high exactly while in its state.
    always_comb begin
        state_d         = state_q;
        elem_cnt_d      = elem_cnt_q;
        vec_cnt_d       = vec_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        matrix_loaded_d = matrix_loaded_q;
        error_d         = error_q;
        res_buf_d       = res_buf_q;

        case (state_q)
            IDLE: begin
                elem_cnt_d = '0;
                vec_cnt_d  = '0;
                wait_cnt_d = '0;
                if (s_valid) begin
                    state_d = (reuse_matrix && matrix_loaded_q) ? LV_CMD : LM_CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            LM_CMD: begin
                elem_cnt_d = '0;
                state_d    = LM_DATA;
            end
            LM_DATA: begin
                if (!s_valid) begin
                    // The engine cannot be stalled, so a gap kills the whole job.
                    error_d         = 1'b1;
                    matrix_loaded_d = 1'b0;
                    elem_cnt_d      = '0;
                    state_d         = IDLE;
                end else if (elem_cnt_q == MAT_LAST) begin
                    matrix_loaded_d = 1'b1;
                    elem_cnt_d      = '0;
                    state_d         = LV_CMD;
                end else begin
                    elem_cnt_d = elem_cnt_q + CW'(1);
                end
            end
            LV_CMD: begin
                elem_cnt_d = '0;
                state_d    = LV_DATA;
            end
            LV_DATA: begin
                if (!s_valid) begin
                    error_d         = 1'b1;
                    matrix_loaded_d = 1'b0;
                    elem_cnt_d      = '0;
                    state_d         = IDLE;
                end else if (elem_cnt_q == CW'(K-1)) begin
                    elem_cnt_d = '0;
                    state_d    = START;
                end else begin
                    elem_cnt_d = elem_cnt_q + CW'(1);
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (done) begin
                    res_buf_d[0] = data_out;
                    vec_cnt_d    = VW'(1);
                    wait_cnt_d   = '0;
                    state_d      = CAPTURE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    error_d    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            CAPTURE: begin
                res_buf_d[vec_cnt_q[IW-1:0]] = data_out;
                if (vec_cnt_q == VEC_LAST) begin
                    vec_cnt_d = '0;
                    state_d   = DRAIN;
                end else begin
                    vec_cnt_d = vec_cnt_q + VW'(1);
                end
            end
            DRAIN: begin
                if (r_ready) begin
                    if (vec_cnt_q == VEC_LAST) begin
                        vec_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        vec_cnt_d = vec_cnt_q + VW'(1);
                    end
                end else begin
                    vec_cnt_d = vec_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d     = (state_d == LM_DATA) || (state_d == LV_DATA);
        load_matrix_d = (state_d == LM_CMD);
        load_vector_d = (state_d == LV_CMD);
        start_d       = (state_d == START);
        r_valid_d     = (state_d == DRAIN);
        busy_d        = (state_d != IDLE);
        if (r_valid_d) begin
            r_data_d = res_buf_d[vec_cnt_d[IW-1:0]];
            r_last_d = (vec_cnt_d == VEC_LAST);
        end else begin
            r_data_d = '0;
            r_last_d = 1'b0;
        end
    end

    // State, counters, result buffer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            elem_cnt_q      <= '0;
            vec_cnt_q       <= '0;
            wait_cnt_q      <= '0;
            matrix_loaded_q <= 1'b0;
            error_q         <= 1'b0;
            for (int i = 0; i < K; i++) begin
                res_buf_q[i] <= '0;
            end
            s_ready_q       <= 1'b0;
            load_matrix_q   <= 1'b0;
            load_vector_q   <= 1'b0;
            start_q         <= 1'b0;
            r_valid_q       <= 1'b0;
            r_last_q        <= 1'b0;
            r_data_q        <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            elem_cnt_q      <= elem_cnt_d;
            vec_cnt_q       <= vec_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            matrix_loaded_q <= matrix_loaded_d;
            error_q         <= error_d;
            res_buf_q       <= res_buf_d;
            s_ready_q       <= s_ready_d;
            load_matrix_q   <= load_matrix_d;
            load_vector_q   <= load_vector_d;
            start_q         <= start_d;
            r_valid_q       <= r_valid_d;
            r_last_q        <= r_last_d;
            r_data_q        <= r_data_d;
            busy_q          <= busy_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign loadMatrix = load_matrix_q;
    assign loadVector = load_vector_q;
    assign start      = start_q;
    assign data_in    = s_ready_q ? s_data : '0;
    assign r_valid    = r_valid_q;
    assign r_data     = r_data_q;
    assign r_last     = r_last_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed bench for mvm_host_driver with K=4, B=8, TIMEOUT=16.
module tb_mvm_host_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        reuse_matrix = 1'b0;
    logic        loadMatrix, loadVector, start;
    logic [7:0]  data_in;
    logic        done = 1'b0;
    logic [15:0] data_out = 16'd0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [15:0] r_data;
    logic        r_last;
    logic        busy, error;

    int checks = 0;
    int errors = 0;

    int lm_cnt = 0, lv_cnt = 0, st_cnt = 0, acc_cnt = 0, multi_cnt = 0, din_bad = 0;
    int lm0, lv0, st0, acc0;

    mvm_host_driver #(.K(4), .B(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .reuse_matrix(reuse_matrix),
        .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
        .data_in(data_in), .done(done), .data_out(data_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Observe commands and handshakes at the active edge.
    always @(posedge clk) begin
        if (loadMatrix) lm_cnt <= lm_cnt + 1;
        if (loadVector) lv_cnt <= lv_cnt + 1;
        if (start)      st_cnt <= st_cnt + 1;
        if (int'(loadMatrix) + int'(loadVector) + int'(start) > 1) multi_cnt <= multi_cnt + 1;
        if (s_valid && s_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (data_in !== s_data) din_bad <= din_bad + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic snap();
        lm0 = lm_cnt; lv0 = lv_cnt; st0 = st_cnt; acc0 = acc_cnt;
    endtask

    task automatic send(input int n, input int base, input bit hold);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 200) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'(base + idx);
            #1;
            if (s_ready) idx++;
            guard++;
        end
        check_eq("send_accepted", idx, n);
        if (!hold) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("start_seen", start, 1'b1);
    endtask

    task automatic respond(input int dly, input logic [15:0] w0, w1, w2, w3, input logic hold_done);
        repeat (dly + 1) @(negedge clk);
        done = 1'b1; data_out = w0;
        @(negedge clk); done = hold_done; data_out = w1;
        @(negedge clk); data_out = w2;
        @(negedge clk); data_out = w3;
        @(negedge clk); done = 1'b0; data_out = 16'hDEAD;
    endtask

    task automatic drain(input logic [15:0] w0, w1, w2, w3, input int stall);
        logic [15:0] exp_w [4];
        int got = 0;
        int cyc = 0;
        int stalled = 0;
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (got == 1 && stalled < stall) begin
                r_ready = 1'b0;
                stalled++;
            end else begin
                r_ready = 1'b1;
            end
            if (r_valid) begin
                if (r_ready) begin
                    check_eq($sformatf("r_data%0d", got), r_data, exp_w[got]);
                    check_eq($sformatf("r_last%0d", got), r_last, (got == 3));
                    got++;
                end else begin
                    check_eq("r_hold", {r_last, r_data}, {1'b0, exp_w[got]});
                end
            end
        end
        check_eq("drain_count", got, 4);
        @(negedge clk);
        r_ready = 1'b0;
        check_eq("drain_idle", {r_valid, busy}, 2'b00);
    endtask

    initial begin
        int n;
        // Reset values.
        @(negedge clk);
        check_eq("rst_ctrl", {s_ready, loadMatrix, loadVector, start, r_valid, r_last, busy, error}, 8'h00);
        check_eq("rst_data", {data_in, r_data}, 24'h0);
        @(negedge clk);
        reset = 1'b1;

        // Full job: matrix + vector, results 10,20,30,40.
        reuse_matrix = 1'b0;
        snap();
        send(20, 1, 1'b0);
        check_eq("j1_lm", lm_cnt - lm0, 1);
        check_eq("j1_lv", lv_cnt - lv0, 1);
        check_eq("j1_acc", acc_cnt - acc0, 20);
        wait_start();
        respond(0, 16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
        check_eq("j1_start", st_cnt - st0, 1);
        drain(16'd10, 16'd20, 16'd30, 16'd40, 0);
        check_eq("j1_err", error, 1'b0);

        // Reused matrix, done held during capture, 3-cycle stall mid-drain.
        reuse_matrix = 1'b1;
        snap();
        send(4, 100, 1'b0);
        check_eq("j2_lm", lm_cnt - lm0, 0);
        check_eq("j2_lv", lv_cnt - lv0, 1);
        check_eq("j2_acc", acc_cnt - acc0, 4);
        wait_start();
        respond(2, 16'h0123, 16'hFFFF, 16'h8000, 16'h0001, 1'b1);
        drain(16'h0123, 16'hFFFF, 16'h8000, 16'h0001, 3);
        check_eq("j2_start", st_cnt - st0, 1);

        // Stream gap at matrix element 7.
        reuse_matrix = 1'b0;
        snap();
        send(7, 1, 1'b0);
        @(negedge clk);
        check_eq("gap_err_busy", {error, busy, s_ready}, 3'b100);
        repeat (5) @(negedge clk);
        check_eq("gap_no_start", st_cnt - st0, 0);
        check_eq("gap_acc", acc_cnt - acc0, 7);

        // Asynchronous reset while loading the vector.
        reuse_matrix = 1'b0;
        send(18, 50, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_ctrl", {s_ready, loadMatrix, loadVector, start, r_valid, r_last, busy, error}, 8'h00);
        check_eq("arst_data", {data_in, r_data}, 24'h0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        snap();
        repeat (3) @(negedge clk);
        check_eq("arst_no_cmd", (lm_cnt - lm0) + (lv_cnt - lv0) + (st_cnt - st0), 0);

        // After reset the matrix must be reloaded; then let the engine time out.
        reuse_matrix = 1'b1;
        snap();
        send(20, 7, 1'b0);
        check_eq("j4_lm", lm_cnt - lm0, 1);
        wait_start();
        check_eq("j4_err_pre", error, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        check_eq("timeout_cycles", n, 17);
        check_eq("timeout_err", {error, r_valid}, 2'b10);

        check_eq("cmd_exclusive", multi_cnt, 0);
        check_eq("data_in_path", din_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
